// File: rtl/fir_window_gen.sv
// fir_window_gen: turns a raster RGB pixel stream into serial 3x3 windows
// (9 beats each, raster order, zero padding outside the image) for the
// 2-D FIR core.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_data/in_valid/     raster pixel input, valid/ready handshake
//   in_ready
//   out_data/out_valid/   window beat output, valid/ready handshake
//   out_ready
//   out_first/out_last    beat 0 / beat 8 of a window
//   frame_done            one-cycle pulse after the final beat of a frame
//   busy                  frame in progress
module fir_window_gen #(
   parameter int IW = 1920,
   parameter int IH = 1080,
   parameter int DW = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_first,
   output logic          out_last,
   output logic          frame_done,
   output logic          busy
);

   localparam int CW = $clog2(IW);
   localparam int RW = $clog2(IH);
   localparam logic [CW-1:0] COL_LAST = CW'(IW - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_RUN,
      S_FLUSH
   } state_t;

   state_t state, state_nx;

   logic [DW-1:0] lb0 [IW];
   logic [DW-1:0] lb1 [IW];
   logic [DW-1:0] win [3][3];

   logic [RW-1:0] row, wr;
   logic [CW-1:0] col, wc, fcol, src_col;
   logic          in_done, fl_end, ser_act, second;
   logic [3:0]    beat;

   logic          acc, hs, step, trig, beat_end, last_hs, pad;
   logic [DW-1:0] col_bot;
   logic [1:0]    br, bc;

   assign in_ready = (state == S_IDLE) || (state == S_FILL) ||
                     ((state == S_RUN) && !ser_act && !in_done);
   assign busy     = (state != S_IDLE);
   assign acc      = in_valid && in_ready;
   assign out_valid = ser_act;
   assign hs       = ser_act && out_ready;
   assign beat_end = hs && (beat == 4'd8);

   // Flush walks the two stored rows once more with a zero bottom row.
   assign step     = (state == S_FLUSH) && !ser_act && !fl_end;
   assign last_hs  = (state == S_FLUSH) && fl_end && beat_end && !second;
   assign src_col  = step ? fcol : col;
   assign col_bot  = step ? '0 : in_data;
   assign trig     = (acc && (row != '0) && (col != '0)) ||
                     (step && (fcol != '0));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (acc) state_nx = S_FILL;
         S_FILL:  if (acc && (col == '0) && (row == RW'(1)))
                     state_nx = S_RUN;
         S_RUN:   if (in_done && !ser_act) state_nx = S_FLUSH;
         S_FLUSH: if (last_hs) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row        <= '0;
         col        <= '0;
         fcol       <= '0;
         wr         <= '0;
         wc         <= '0;
         beat       <= '0;
         in_done    <= 1'b0;
         fl_end     <= 1'b0;
         ser_act    <= 1'b0;
         second     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= last_hs;
         if (acc) begin
            if (col == COL_LAST) begin
               col <= '0;
               if (row == ROW_LAST) in_done <= 1'b1;
               else                 row <= row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         if (step) begin
            if (fcol == COL_LAST) fl_end <= 1'b1;
            else                  fcol <= fcol + CW'(1);
         end
         if (trig) begin
            ser_act <= 1'b1;
            beat    <= '0;
            wr      <= step ? ROW_LAST : row - RW'(1);
            wc      <= src_col - CW'(1);
            second  <= (src_col == COL_LAST);
         end else if (hs) begin
            if (beat == 4'd8) begin
               if (second) begin
                  second <= 1'b0;
                  beat   <= '0;
                  wc     <= wc + CW'(1);
               end else begin
                  ser_act <= 1'b0;
               end
            end else begin
               beat <= beat + 4'd1;
            end
         end
         if (last_hs) begin
            row     <= '0;
            col     <= '0;
            fcol    <= '0;
            in_done <= 1'b0;
            fl_end  <= 1'b0;
         end
      end
   end

   // Line buffers and window hold data only; padding is decided purely
   // from the window centre coordinates, so stale contents never leak.
   always_ff @(posedge clk) begin
      if (acc || step) begin
         for (int i = 0; i < 3; i++) begin
            win[i][0] <= win[i][1];
            win[i][1] <= win[i][2];
         end
         win[0][2] <= lb1[src_col];
         win[1][2] <= lb0[src_col];
         win[2][2] <= col_bot;
      end else if (beat_end && second) begin
         // Row-end second window: slide one column right.
         for (int i = 0; i < 3; i++) begin
            win[i][0] <= win[i][1];
            win[i][1] <= win[i][2];
            win[i][2] <= '0;
         end
      end
      if (acc) begin
         lb0[col] <= in_data;
         lb1[col] <= lb0[col];
      end
   end

   always_comb begin
      br = 2'd0;
      bc = 2'd0;
      case (beat)
         4'd1: bc = 2'd1;
         4'd2: bc = 2'd2;
         4'd3: br = 2'd1;
         4'd4: begin br = 2'd1; bc = 2'd1; end
         4'd5: begin br = 2'd1; bc = 2'd2; end
         4'd6: br = 2'd2;
         4'd7: begin br = 2'd2; bc = 2'd1; end
         4'd8: begin br = 2'd2; bc = 2'd2; end
         default: ;
      endcase
   end

   assign pad = ((br == 2'd0) && (wr == '0)) ||
                ((br == 2'd2) && (wr == ROW_LAST)) ||
                ((bc == 2'd0) && (wc == '0)) ||
                ((bc == 2'd2) && (wc == COL_LAST));

   assign out_data  = (!ser_act || pad) ? '0 : win[br][bc];
   assign out_first = ser_act && (beat == 4'd0);
   assign out_last  = ser_act && (beat == 4'd8);

endmodule
